// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, the HALT
// opcode, instruction size and immediate field positions used for branch
// target computation.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_UPDATE,
        ST_HALTED
    } fetch_state_e;

    localparam logic [10:0] HALT_OPCODE = 11'h7FF;
    localparam int          INSTR_BYTES = 4;

    // Opcode field presented to control
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 21;

    // B: imm26, CBZ/CBNZ: imm19 (both word offsets)
    localparam int IMM26_MSB = 25;
    localparam int IMM26_LSB = 0;
    localparam int IMM26_W   = IMM26_MSB - IMM26_LSB + 1;
    localparam int IMM19_MSB = 23;
    localparam int IMM19_LSB = 5;
    localparam int IMM19_W   = IMM19_MSB - IMM19_LSB + 1;

endpackage

// File: rtl/cpu_fetch_if.sv
// Instruction-memory request/acknowledge bus.
//   imem_req   : fetch request, held until ack
//   imem_addr  : fetch address
//   imem_ack   : one-cycle pulse, imem_rdata valid in the same cycle
//   imem_rdata : fetched instruction word
// master = fetch stage, slave = instruction memory.
interface cpu_fetch_if #(
    parameter int PC_WIDTH = 64
) ();
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [31:0]         imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/cpu_branch_target.sv
// Combinational branch target: pc + (sext(imm) << 2), where imm is imm26
// for unconditional B and imm19 for CBZ/CBNZ.
//   pc          : address of the branch instruction
//   instruction : branch instruction word
//   Branch      : selects imm26 (1) or imm19 (0)
//   target      : resulting address, modulo 2^PC_WIDTH
module cpu_branch_target
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = 64
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [31:0]         instruction,
    input  logic                Branch,
    output logic [PC_WIDTH-1:0] target
);
    logic [IMM26_W-1:0]  imm26;
    logic [IMM19_W-1:0]  imm19;
    logic [PC_WIDTH-1:0] off26;
    logic [PC_WIDTH-1:0] off19;
    logic                unused_opc;

    assign imm26 = instruction[IMM26_MSB:IMM26_LSB];
    assign imm19 = instruction[IMM19_MSB:IMM19_LSB];

    // Sign-extend and scale word offset to bytes (two zero LSBs)
    assign off26 = {{(PC_WIDTH-IMM26_W-2){imm26[IMM26_W-1]}}, imm26, 2'b00};
    assign off19 = {{(PC_WIDTH-IMM19_W-2){imm19[IMM19_W-1]}}, imm19, 2'b00};

    assign target = pc + (Branch ? off26 : off19);

    // Opcode bits play no part in the target
    assign unused_opc = ^instruction[31:26];
endmodule

// File: rtl/cpu_fetch.sv
// Instruction-fetch stage. Owns the PC, fetches over a req/ack bus,
// holds the instruction for EXEC_CYCLES cycles while control settles,
// then selects the next PC from the branch inputs. Stops on HALT.
//   clk, reset    : clock, async active-high reset
//   imem          : instruction-memory bus (master)
//   instruction   : latched instruction register
//   inst31_21     : opcode field to control
//   instr_valid   : high during the execute window
//   pc            : address of the current instruction
//   Branch, BranchZero, BranchNonZero, alu_zero : next-PC select inputs
//   retire        : one-cycle pulse when the PC advances
//   halted        : sticky halt indicator
module cpu_fetch
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH    = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  EXEC_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    cpu_fetch_if.master         imem,
    output logic [31:0]         instruction,
    output logic [10:0]         inst31_21,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] pc,
    input  logic                Branch,
    input  logic                BranchZero,
    input  logic                BranchNonZero,
    input  logic                alu_zero,
    output logic                retire,
    output logic                halted
);
    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    // Branch decision captured at the end of EXEC, applied in UPDATE
    logic                taken_q, taken_d;
    logic                br_q, br_d;
    logic [PC_WIDTH-1:0] target;

    cpu_branch_target #(.PC_WIDTH(PC_WIDTH)) u_target (
        .pc          (pc_q),
        .instruction (instr_q),
        .Branch      (br_q),
        .target      (target)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            cnt_q   <= '0;
            taken_q <= 1'b0;
            br_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            taken_q <= taken_d;
            br_q    <= br_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        taken_d = taken_q;
        br_d    = br_q;
        unique case (state_q)
            // Single cycle that swallows any ack left over from before reset
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    cnt_d   = '0;
                    state_d = (imem.imem_rdata[OPC_MSB:OPC_LSB] == HALT_OPCODE)
                              ? ST_HALTED : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    br_d    = Branch;
                    taken_d = Branch | (BranchZero & alu_zero)
                                     | (BranchNonZero & ~alu_zero);
                    state_d = ST_UPDATE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_UPDATE: begin
                pc_d    = taken_q ? target : pc_q + PC_WIDTH'(INSTR_BYTES);
                state_d = ST_FETCH;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign imem.imem_req  = (state_q == ST_FETCH);
    assign imem.imem_addr = pc_q;
    assign instruction    = instr_q;
    assign inst31_21      = instr_q[OPC_MSB:OPC_LSB];
    assign instr_valid    = (state_q == ST_EXEC);
    assign pc             = pc_q;
    assign retire         = (state_q == ST_UPDATE);
    assign halted         = (state_q == ST_HALTED);
endmodule

// File: tb/tb_cpu_fetch.sv
module tb_cpu_fetch;
    logic clk = 1'b0;
    logic reset;
    logic Branch, BranchZero, BranchNonZero, alu_zero;

    logic [31:0] instruction, instruction2;
    logic [10:0] inst31_21, inst31_21_2;
    logic        instr_valid, instr_valid2;
    logic [63:0] pc, pc2;
    logic        retire, retire2, halted, halted2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_fetch_if #(.PC_WIDTH(64)) imem ();
    cpu_fetch_if #(.PC_WIDTH(64)) imem2 ();

    cpu_fetch #(.PC_WIDTH(64), .RESET_PC(64'h0), .EXEC_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .imem(imem),
        .instruction(instruction), .inst31_21(inst31_21),
        .instr_valid(instr_valid), .pc(pc),
        .Branch(Branch), .BranchZero(BranchZero),
        .BranchNonZero(BranchNonZero), .alu_zero(alu_zero),
        .retire(retire), .halted(halted)
    );

    cpu_fetch #(.PC_WIDTH(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .EXEC_CYCLES(2)) dut_wrap (
        .clk(clk), .reset(reset), .imem(imem2),
        .instruction(instruction2), .inst31_21(inst31_21_2),
        .instr_valid(instr_valid2), .pc(pc2),
        .Branch(Branch), .BranchZero(BranchZero),
        .BranchNonZero(BranchNonZero), .alu_zero(alu_zero),
        .retire(retire2), .halted(halted2)
    );

    // Fetch one instruction at address a, return word w after 'waits'
    // cycles, present branch inputs during EXEC and expect next pc np.
    task automatic run_instr(input string nm, input logic [63:0] a, input logic [31:0] w,
                             input int waits, input logic br, input logic bz,
                             input logic bnz, input logic z, input logic [63:0] np);
        int n = 0;
        logic [10:0] opc;
        opc = w[31:21];
        while (imem.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== a) begin
            errors++;
            $display("FAIL %s req/addr: got req=%b addr=%h want req=1 addr=%h", nm, imem.imem_req, imem.imem_addr, a);
        end
        repeat (waits) begin
            @(negedge clk);
            checks++;
            if (imem.imem_req !== 1'b1) begin
                errors++;
                $display("FAIL %s req_hold: got %b want 1", nm, imem.imem_req);
            end
        end
        imem.imem_ack = 1'b1;
        imem.imem_rdata = w;
        @(negedge clk);
        imem.imem_ack = 1'b0;
        imem.imem_rdata = '0;
        Branch = br; BranchZero = bz; BranchNonZero = bnz; alu_zero = z;
        checks++;
        if (instr_valid !== 1'b1 || inst31_21 !== opc || imem.imem_req !== 1'b0 || instruction !== w) begin
            errors++;
            $display("FAIL %s exec0: got valid=%b op=%h req=%b instr=%h want valid=1 op=%h req=0 instr=%h",
                     nm, instr_valid, inst31_21, imem.imem_req, instruction, opc, w);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || retire !== 1'b0) begin
            errors++;
            $display("FAIL %s exec1: got valid=%b retire=%b want valid=1 retire=0", nm, instr_valid, retire);
        end
        @(negedge clk);
        Branch = 0; BranchZero = 0; BranchNonZero = 0; alu_zero = 0;
        checks++;
        if (retire !== 1'b1 || instr_valid !== 1'b0 || pc !== a) begin
            errors++;
            $display("FAIL %s update: got retire=%b valid=%b pc=%h want retire=1 valid=0 pc=%h", nm, retire, instr_valid, pc, a);
        end
        @(negedge clk);
        checks++;
        if (retire !== 1'b0 || pc !== np || imem.imem_req !== 1'b1 || imem.imem_addr !== np) begin
            errors++;
            $display("FAIL %s next_pc: got retire=%b pc=%h req=%b addr=%h want retire=0 pc=%h req=1",
                     nm, retire, pc, imem.imem_req, imem.imem_addr, np);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Branch = 0; BranchZero = 0; BranchNonZero = 0; alu_zero = 0;
        imem.imem_ack = 0; imem.imem_rdata = '0;
        imem2.imem_ack = 0; imem2.imem_rdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (imem.imem_req !== 1'b0 || imem.imem_addr !== 64'h0 || pc !== 64'h0 || instruction !== 32'h0 ||
            inst31_21 !== 11'h0 || instr_valid !== 1'b0 || retire !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got req=%b addr=%h pc=%h instr=%h valid=%b retire=%b halted=%b want all 0",
                     imem.imem_req, imem.imem_addr, pc, instruction, instr_valid, retire, halted);
        end
        checks++;
        if (pc2 !== 64'hFFFF_FFFF_FFFF_FFFC || imem2.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("FAIL reset_pc_param: got pc=%h addr=%h want fffffffffffffffc", pc2, imem2.imem_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 64'h0) begin
            errors++;
            $display("FAIL reset_first_fetch: got req=%b addr=%h want req=1 addr=0", imem.imem_req, imem.imem_addr);
        end
    endtask

    task automatic test_sequential();
        run_instr("seq0", 64'h0, 32'h8B02_0020, 0, 0, 0, 0, 0, 64'h4);
        checks++;
        if (inst31_21 !== 11'b10001011000) begin
            errors++;
            $display("FAIL seq_opcode: got %b want 10001011000", inst31_21);
        end
        run_instr("seq1", 64'h4, 32'h8B02_0020, 3, 0, 0, 0, 0, 64'h8);
    endtask

    task automatic test_branch();
        run_instr("b_to10",   64'h8,  32'h1400_0002, 0, 1, 0, 0, 0, 64'h10);
        run_instr("b_plus3",  64'h10, 32'h1400_0003, 1, 1, 0, 0, 0, 64'h1C);
        run_instr("b_minus3", 64'h1C, 32'h17FF_FFFD, 0, 1, 0, 0, 0, 64'h10);
        run_instr("b_minus1", 64'h10, 32'h17FF_FFFF, 0, 1, 0, 0, 0, 64'hC);
        // Branch wins over a not-taken CBNZ; imm26 of this word is 5
        run_instr("b_prio",   64'hC,  32'h1400_0005, 0, 1, 0, 1, 1, 64'h20);
    endtask

    task automatic test_cbz_cbnz();
        run_instr("cbz_t",   64'h20, 32'hB400_0062, 0, 0, 1, 0, 1, 64'h2C);
        run_instr("back0",   64'h2C, 32'h17FF_FFFD, 0, 1, 0, 0, 0, 64'h20);
        run_instr("cbz_nt",  64'h20, 32'hB400_0062, 2, 0, 1, 0, 0, 64'h24);
        run_instr("back1",   64'h24, 32'h17FF_FFFF, 0, 1, 0, 0, 0, 64'h20);
        run_instr("cbnz_nt", 64'h20, 32'hB500_0062, 0, 0, 0, 1, 1, 64'h24);
        run_instr("back2",   64'h24, 32'h17FF_FFFF, 0, 1, 0, 0, 0, 64'h20);
        run_instr("cbnz_t",  64'h20, 32'hB500_0062, 0, 0, 0, 1, 0, 64'h2C);
        run_instr("to30",    64'h2C, 32'h1400_0001, 0, 1, 0, 0, 0, 64'h30);
    endtask

    task automatic test_halt();
        int bad = 0;
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 64'h30) begin
            errors++;
            $display("FAIL halt_addr: got req=%b addr=%h want req=1 addr=30", imem.imem_req, imem.imem_addr);
        end
        imem.imem_ack = 1'b1;
        imem.imem_rdata = 32'hFFE0_0000;
        @(negedge clk);
        imem.imem_ack = 1'b0;
        imem.imem_rdata = '0;
        checks++;
        if (halted !== 1'b1 || instr_valid !== 1'b0 || imem.imem_req !== 1'b0 ||
            instruction !== 32'hFFE0_0000 || inst31_21 !== 11'h7FF) begin
            errors++;
            $display("FAIL halt_enter: got halted=%b valid=%b req=%b instr=%h op=%h want 1 0 0 ffe00000 7ff",
                     halted, instr_valid, imem.imem_req, instruction, inst31_21);
        end
        // A stray ack while halted must be ignored
        imem.imem_ack = 1'b1;
        imem.imem_rdata = 32'h8B02_0020;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            imem.imem_ack = 1'b0;
            if (imem.imem_req !== 1'b0 || retire !== 1'b0 || pc !== 64'h30 ||
                halted !== 1'b1 || instruction !== 32'hFFE0_0000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halt_hold: %0d bad cycles (req/retire/pc/halted/instr) want 0", bad);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (halted !== 1'b0 || pc !== 64'h0) begin
            errors++;
            $display("FAIL halt_reset: got halted=%b pc=%h want halted=0 pc=0", halted, pc);
        end
        reset = 1'b0;
        @(negedge clk);
        run_instr("post_halt", 64'h0, 32'h8B02_0020, 0, 0, 0, 0, 0, 64'h4);
    endtask

    task automatic test_reset_mid_fetch();
        // Fetch is pending at 0x4 here
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        imem.imem_ack = 1'b1;
        imem.imem_rdata = 32'h8B02_0020;
        @(negedge clk);
        imem.imem_ack = 1'b0;
        imem.imem_rdata = '0;
        checks++;
        if (instruction !== 32'h0 || instr_valid !== 1'b0 || imem.imem_req !== 1'b1 || imem.imem_addr !== 64'h0) begin
            errors++;
            $display("FAIL stale_ack: got instr=%h valid=%b req=%b addr=%h want 0 0 1 0",
                     instruction, instr_valid, imem.imem_req, imem.imem_addr);
        end
        // Reset in the middle of EXEC: no retire, pc stays at reset value
        run_instr("pre_midexec", 64'h0, 32'h8B02_0020, 0, 0, 0, 0, 0, 64'h4);
        imem.imem_ack = 1'b1;
        imem.imem_rdata = 32'h1400_0003;
        @(negedge clk);
        imem.imem_ack = 1'b0;
        Branch = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        Branch = 1'b0;
        checks++;
        if (pc !== 64'h0 || retire !== 1'b0 || instr_valid !== 1'b0 || instruction !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_exec: got pc=%h retire=%b valid=%b instr=%h want 0 0 0 0", pc, retire, instr_valid, instruction);
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        while (imem2.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        imem2.imem_ack = 1'b1;
        imem2.imem_rdata = 32'h8B02_0020;
        @(negedge clk);
        imem2.imem_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pc2 !== 64'h0 || imem2.imem_req !== 1'b1 || imem2.imem_addr !== 64'h0) begin
            errors++;
            $display("FAIL wrap: got pc=%h req=%b addr=%h want pc=0 req=1", pc2, imem2.imem_req, imem2.imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_cbz_cbnz();
        test_halt();
        test_reset_mid_fetch();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_fetch.md
Name: cpu_fetch

Overview:
- Instruction-fetch stage directly upstream of cpu_control.
- Owns the 64-bit PC and issues a req/ack handshake to instruction memory.
- Latches the returned instruction and presents inst31_21 to control for a fixed execute window.
- Selects the next PC from the branch/zero inputs; stops on HALT (inst[31:21] = 11'b11111111111).

Parameters:
- PC_WIDTH, 64, width of PC and imem_addr.
- RESET_PC, 64'h0, PC loaded on reset.
- EXEC_CYCLES, 2, cycles instr_valid is held per instruction (≥1); covers control-path settle.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held until ack.
- imem_addr  out  PC_WIDTH  fetch address (= pc while imem_req=1).
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instruction  out  32  latched instruction register.
- inst31_21  out  11  instruction[31:21], fed to cpu_control.
- instr_valid  out  1  high during the execute window.
- pc  out  PC_WIDTH  address of the current instruction.
- Branch  in  1  unconditional branch (from control).
- BranchZero  in  1  CBZ (from control).
- BranchNonZero  in  1  CBNZ (from control).
- alu_zero  in  1  ALU zero flag.
- retire  out  1  one-cycle pulse when the PC advances.
- halted  out  1  sticky halt indicator.

Behaviour:
- States: IDLE, FETCH, EXEC, UPDATE, HALTED.
- Reset (async): state=IDLE, pc=RESET_PC, instruction=32'h0, exec counter=0. All outputs 0, except pc and imem_addr, which equal RESET_PC.
- IDLE: one cycle, imem_req=0, imem_ack ignored (discards stale acks from before reset) -> FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - imem_ack=1: instruction <= imem_rdata, counter <= 0, then:
    - -> HALTED if imem_rdata[31:21] == 11'h7FF;
    - -> EXEC otherwise.
  - imem_ack=0: stay in FETCH; no timeout.
  - Request drops the cycle after ack.
- EXEC: instr_valid=1, counter increments each cycle.
  - When counter == EXEC_CYCLES-1, sample Branch, BranchZero, BranchNonZero, alu_zero -> UPDATE.
  - Fetch-to-first-valid latency: 1 cycle after ack.
- UPDATE: instr_valid=0, retire=1 for this cycle only -> FETCH.
  - pc <= taken ? target : pc+4.
  - taken = Branch | (BranchZero & alu_zero) | (BranchNonZero & ~alu_zero).
  - Target when Branch=1: pc + (sext(instruction[25:0]) << 2).
  - Target otherwise: pc + (sext(instruction[23:5]) << 2).
  - Branch has priority if multiple branch inputs are high.
  - Arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
- HALTED: halted=1, imem_req=0, instr_valid=0.
  - pc stays at the HALT instruction's address.
  - instruction and inst31_21 hold the HALT encoding (control decodes it as a nop).
  - Remains until reset.
- imem_ack outside FETCH is ignored. Ack and reset in the same cycle: reset wins.
- Reset mid-EXEC or mid-UPDATE: immediate return to reset values; no retire pulse; no PC update.
- Throughput: one instruction per (EXEC_CYCLES + 2 + memory wait) cycles.

Decomposition:
- Shared package cpu_pkg:
  - fetch state enum;
  - HALT_OPCODE = 11'h7FF;
  - INSTR_BYTES = 4;
  - field positions for imm26 [25:0] and imm19 [23:5].
- Sub-module cpu_branch_target: combinational; inputs pc, instruction, Branch; output target address.
- Next-PC mux and FSM stay in cpu_fetch.

Test Plan:
- Sequential fetch: memory returns ADD (0x8B020020) at 0x0 and 0x4, ack after 0 and 3 wait cycles -> imem_addr = 0x0 then 0x4. instr_valid high 2 cycles each, inst31_21 = 11'b10001011000, retire pulses, pc ends at 0x8.
- B taken: at pc=0x10, instruction 0x14000003, Branch=1 -> next imem_addr = 0x1C. B with imm26 = all ones at pc=0x10 -> 0xC.
- CBZ/CBNZ: at pc=0x20, instruction 0xB4000062 (imm19=3), BranchZero=1.
  - alu_zero=1 -> pc = 0x2C;
  - alu_zero=0 -> pc = 0x24;
  - CBNZ with the same flags gives the inverse results.
- HALT: ack with 0xFFE00000 at pc=0x30 -> halted=1, imem_req stays 0 for 20 cycles, pc=0x30, no retire. Reset -> pc=0x0, fetch resumes.
- Reset mid-fetch: assert reset while imem_req=1; deliver a stale ack during the first post-reset cycle -> ack ignored, instruction=0. Fetch from 0x0 restarts one cycle later.
- Wrap: RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC, non-branch instruction -> next pc = 0x0.
